// File: rtl/monitor_contador_5bit_pkg.sv
// Shared constants for the ripple down-counter monitor: default widths and
// the checker FSM state encoding.
package monitor_contador_5bit_pkg;

    localparam int unsigned WIDTH_DEF  = 5;
    localparam int unsigned WRAP_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'b00;
    localparam state_t ST_ACQUIRE = 2'b01;
    localparam state_t ST_TRACK   = 2'b10;
    localparam state_t ST_FAULT   = 2'b11;

endpackage : monitor_contador_5bit_pkg

// File: rtl/sincroniza_bus.sv
// Two-flop sample register that brings the asynchronous ripple count into the
// clk domain; both stages clear on synchronous reset.
module sincroniza_bus #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sincroniza_bus

// File: rtl/monitor_contador_5bit.sv
// Health monitor for the 5-bit ripple down-counter: accepts hold or
// decrement-by-one steps, flags terminal count and wraps, latches any fault.
module monitor_contador_5bit
    import monitor_contador_5bit_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              enable,
    input  logic              clr_err,
    output logic              tc_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  count_sync,
    output logic              tracking,
    output logic              err,
    output logic [WIDTH-1:0]  err_prev,
    output logic [WIDTH-1:0]  err_got
);

    logic [WIDTH-1:0] s2;

    sincroniza_bus #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (q_in),
        .q_o (s2)
    );

    state_t            state_q,   state_d;
    logic [WIDTH-1:0]  ref_q,     ref_d;
    logic [WIDTH-1:0]  count_q,   count_d;
    logic [WRAP_W-1:0] wrap_q,    wrap_d;
    logic              err_q,     err_d;
    logic [WIDTH-1:0]  eprev_q,   eprev_d;
    logic [WIDTH-1:0]  egot_q,    egot_d;
    logic              tc_q,      tc_d;
    logic              wrp_q,     wrp_d;
    logic              track_q,   track_d;

    logic [WIDTH-1:0]  ref_dec;
    logic              step_hold;
    logic              step_dec;

    // Expected next value of a down-counter, wrapping naturally in WIDTH bits
    assign ref_dec   = ref_q - WIDTH'(1);
    assign step_hold = (s2 == ref_q);
    assign step_dec  = (s2 == ref_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ref_q   <= '0;
            count_q <= '0;
            wrap_q  <= '0;
            err_q   <= 1'b0;
            eprev_q <= '0;
            egot_q  <= '0;
            tc_q    <= 1'b0;
            wrp_q   <= 1'b0;
            track_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            eprev_q <= eprev_d;
            egot_q  <= egot_d;
            tc_q    <= tc_d;
            wrp_q   <= wrp_d;
            track_q <= track_d;
        end
    end

    // Next-state and datapath updates; clr_err outranks enable and checks
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        count_d = count_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        eprev_d = eprev_q;
        egot_d  = egot_q;
        tc_d    = 1'b0;
        wrp_d   = 1'b0;

        if (clr_err) begin
            err_d   = 1'b0;
            eprev_d = '0;
            egot_d  = '0;
            state_d = enable ? ST_ACQUIRE : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        ref_d   = s2;
                        count_d = s2;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (step_hold) begin
                        state_d = ST_TRACK;
                    end else if (step_dec) begin
                        ref_d   = s2;
                        count_d = s2;
                        if (ref_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                        end
                        if (ref_q == '0) begin
                            wrp_d = 1'b1;
                            if (wrap_q != '1) begin
                                wrap_d = wrap_q + WRAP_W'(1);
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        eprev_d = ref_q;
                        egot_d  = s2;
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign track_d = (state_d == ST_TRACK);

    assign tc_pulse   = tc_q;
    assign wrap_pulse = wrp_q;
    assign wrap_count = wrap_q;
    assign count_sync = count_q;
    assign tracking   = track_q;
    assign err        = err_q;
    assign err_prev   = eprev_q;
    assign err_got    = egot_q;

endmodule : monitor_contador_5bit

// File: tb/tb_monitor_contador_5bit.sv
// Directed bench for monitor_contador_5bit: normal count-down, hold, fault,
// clear/reacquire, wrap saturation, reset and clr_err priority.
module tb_monitor_contador_5bit;

    logic       clk;
    logic       rst;
    logic [4:0] q_in;
    logic       enable;
    logic       clr_err;
    logic       tc_pulse;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic [4:0] count_sync;
    logic       tracking;
    logic       err;
    logic [4:0] err_prev;
    logic [4:0] err_got;

    int checks   = 0;
    int errors   = 0;
    int both_cnt = 0;

    monitor_contador_5bit #(
        .WIDTH  (5),
        .WRAP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .enable     (enable),
        .clr_err    (clr_err),
        .tc_pulse   (tc_pulse),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .count_sync (count_sync),
        .tracking   (tracking),
        .err        (err),
        .err_prev   (err_prev),
        .err_got    (err_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (tc_pulse && wrap_pulse) both_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int tc_n, tc_idx, wr_n, wr_idx, pulses, wraps, n;
        logic [4:0] v;

        rst = 1'b1; enable = 1'b0; clr_err = 1'b0; q_in = 5'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_tc",    32'(tc_pulse),   32'd0);
        chk("rst_wrap",  32'(wrap_pulse), 32'd0);
        chk("rst_wcnt",  32'(wrap_count), 32'd0);
        chk("rst_cnt",   32'(count_sync), 32'd0);
        chk("rst_track", 32'(tracking),   32'd0);
        chk("rst_err",   32'(err),        32'd0);
        chk("rst_eprev", 32'(err_prev),   32'd0);
        chk("rst_egot",  32'(err_got),    32'd0);

        // Normal run: preload 31, acquire, then 30..0,31,30
        q_in = 5'd31;
        tick(); tick();
        enable = 1'b1;
        tick();
        chk("acq_track0", 32'(tracking), 32'd0);
        tick();
        chk("acq_track1", 32'(tracking),   32'd1);
        chk("acq_cnt",    32'(count_sync), 32'd31);
        tc_n = 0; tc_idx = -1; wr_n = 0; wr_idx = -1;
        for (int i = 0; i < 36; i++) begin
            if (i <= 30)      q_in = 5'(30 - i);
            else if (i == 31) q_in = 5'd31;
            else              q_in = 5'd30;
            tick();
            if (tc_pulse)   begin tc_n++; tc_idx = i; end
            if (wrap_pulse) begin wr_n++; wr_idx = i; end
        end
        chk("run_tc_n",   32'(tc_n),       32'd1);
        chk("run_tc_idx", 32'(tc_idx),     32'd32);
        chk("run_wr_n",   32'(wr_n),       32'd1);
        chk("run_wr_idx", 32'(wr_idx),     32'd33);
        chk("run_wcnt",   32'(wrap_count), 32'd1);
        chk("run_err",    32'(err),        32'd0);
        chk("run_cnt",    32'(count_sync), 32'd30);

        // Hold tolerance: reacquire at 10, then 10,10,10,9
        enable = 1'b0; q_in = 5'd10;
        tick(); tick();
        chk("idle_track", 32'(tracking),   32'd0);
        chk("idle_wcnt",  32'(wrap_count), 32'd1);
        enable = 1'b1;
        tick(); tick();
        chk("hold_acq", 32'(count_sync), 32'd10);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            q_in = (i < 3) ? 5'd10 : 5'd9;
            tick();
            if (tc_pulse || wrap_pulse) pulses++;
        end
        chk("hold_err",    32'(err),        32'd0);
        chk("hold_cnt",    32'(count_sync), 32'd9);
        chk("hold_pulses", 32'(pulses),     32'd0);

        // Illegal step: reacquire at 12, present 9
        enable = 1'b0; q_in = 5'd12;
        tick(); tick();
        enable = 1'b1;
        tick(); tick();
        chk("ill_ref", 32'(count_sync), 32'd12);
        q_in = 5'd9;
        tick(); tick();
        chk("ill_pre_err", 32'(err), 32'd0);
        tick();
        chk("ill_err",   32'(err),        32'd1);
        chk("ill_prev",  32'(err_prev),   32'd12);
        chk("ill_got",   32'(err_got),    32'd9);
        chk("ill_track", 32'(tracking),   32'd0);
        chk("ill_cnt",   32'(count_sync), 32'd12);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            q_in = (i % 2 == 0) ? 5'd0 : 5'd31;
            tick();
            if (tc_pulse || wrap_pulse) pulses++;
        end
        chk("flt_err",    32'(err),        32'd1);
        chk("flt_prev",   32'(err_prev),   32'd12);
        chk("flt_got",    32'(err_got),    32'd9);
        chk("flt_wcnt",   32'(wrap_count), 32'd1);
        chk("flt_pulses", 32'(pulses),     32'd0);
        chk("flt_track",  32'(tracking),   32'd0);

        // Clear and reacquire at 5
        q_in = 5'd5;
        tick(); tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err",   32'(err),      32'd0);
        chk("clr_prev",  32'(err_prev), 32'd0);
        chk("clr_got",   32'(err_got),  32'd0);
        chk("clr_track", 32'(tracking), 32'd0);
        tick();
        chk("clr_track1", 32'(tracking),   32'd1);
        chk("clr_cnt",    32'(count_sync), 32'd5);
        chk("clr_wcnt",   32'(wrap_count), 32'd1);

        // Saturation: continuous count-down through 260 wraps
        v = 5'd5; wraps = 0; n = 0;
        while (wraps < 260 && n < 9000) begin
            v = v - 5'd1;
            q_in = v;
            tick();
            n++;
            if (wrap_pulse) wraps++;
        end
        chk("sat_wraps", 32'(wraps),      32'd260);
        chk("sat_wcnt",  32'(wrap_count), 32'd255);
        chk("sat_err",   32'(err),        32'd0);
        chk("sat_track", 32'(tracking),   32'd1);
        chk("sat_both",  32'(both_cnt),   32'd0);

        // Reset one cycle after 1 -> 0 has been sampled
        enable = 1'b0; q_in = 5'd2;
        tick(); tick();
        enable = 1'b1;
        tick(); tick();
        q_in = 5'd1;
        tick(); tick();
        q_in = 5'd0;
        tick();
        chk("pre_rst_cnt", 32'(count_sync), 32'd1);
        tick();
        chk("pre_rst_tc", 32'(tc_pulse), 32'd0);
        rst = 1'b1; enable = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_tc",    32'(tc_pulse),   32'd0);
        chk("mid_rst_wcnt",  32'(wrap_count), 32'd0);
        chk("mid_rst_cnt",   32'(count_sync), 32'd0);
        chk("mid_rst_track", 32'(tracking),   32'd0);
        chk("mid_rst_err",   32'(err),        32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tc_pulse) pulses++;
        end
        chk("post_rst_tc", 32'(pulses), 32'd0);

        // clr_err coincident with a bad sample
        q_in = 5'd20;
        tick(); tick();
        enable = 1'b1;
        tick(); tick();
        chk("pri_acq", 32'(count_sync), 32'd20);
        q_in = 5'd3;
        tick(); tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("pri_err",   32'(err),      32'd0);
        chk("pri_got",   32'(err_got),  32'd0);
        chk("pri_track", 32'(tracking), 32'd0);
        tick();
        chk("pri_err1",   32'(err),        32'd0);
        chk("pri_track1", 32'(tracking),   32'd1);
        chk("pri_cnt",    32'(count_sync), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_monitor_contador_5bit
